counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
- Parametrised successor to the single-channel modulo counter: NUM_CH independent up/down counters, each CNT_WIDTH wide.
- Each channel has a runtime-programmable terminal value (limit) and a per-channel wrap/saturate mode.
- Each channel produces registered wrap/overflow pulses.
- Used for timeout, retry and round-robin bookkeeping in the pipeline and LSU, wherever several counters share one clock domain.

Parameters:
- NUM_CH, 4, number of counter channels.
- CNT_WIDTH, 6, bits per counter.
- CNT_MAX, 39, reset value of every channel's limit register; must be < 2**CNT_WIDTH.
- RST_VAL, 0, reset value of every counter; must be <= CNT_MAX.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cnt_add_i  input  NUM_CH  per-channel increment request.
- cnt_sub_i  input  NUM_CH  per-channel decrement request.
- cnt_set_i  input  NUM_CH  per-channel load request.
- cnt_set_vector_i  input  NUM_CH*CNT_WIDTH  load values; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- lim_wr_i  input  NUM_CH  per-channel limit write.
- lim_vector_i  input  NUM_CH*CNT_WIDTH  new limit values, packed the same way.
- sat_mode_i  input  NUM_CH  1 = saturate at the bounds, 0 = wrap.
- cnt_o  output  NUM_CH*CNT_WIDTH  current counts (registered).
- cnt_end_o  output  NUM_CH  cnt == limit (combinational from registers).
- cnt_start_o  output  NUM_CH  cnt == 0 (combinational from registers).
- wrap_o  output  NUM_CH  one-cycle registered wrap/overflow pulse.

Behaviour:
- Reset: asynchronous, active-high. While rst = 1: every cnt = RST_VAL, every lim = CNT_MAX, wrap_o = 0. Outputs hold these values from assertion until the first edge after release.
- All state updates on the rising edge of clk.
- Per-channel next-count priority, evaluated against the current lim:
  - 1. set: cnt <= min(set value, lim). No wrap pulse.
  - 2. add and sub both high: hold. No pulse.
  - 3. add: if cnt == lim, wrap mode gives 0 and saturate mode holds lim; both assert wrap_o next cycle. Otherwise cnt + 1.
  - 4. sub: if cnt == 0, wrap mode gives lim and saturate mode holds 0; both assert wrap_o next cycle. Otherwise cnt - 1.
  - 5. none: hold.
- Out-of-range count: if cnt > lim (possible only after a limit write), add behaves as cnt == lim. Clamping below normally prevents this state.
- Limit write: lim <= new value on the same edge. If the computed next count exceeds the new limit, next count = new limit; the clamp overrides any add/sub result. The wrap pulse from that add/sub still fires.
- Limit of 0: the counter stays at 0 and every add or sub produces a wrap pulse.
- wrap_o: registered, so it is high exactly one cycle after the wrap or overflow edge. Back-to-back wrap events give continuous high.
- Arithmetic is modulo 2**CNT_WIDTH internally but can never exceed lim. Channels are fully independent unless the optional feature is enabled.

Optional Feature:
- Macro: COUNTER_BANK_CASCADE_EN.
- With the macro: channel i (i > 0) also increments on the same edge that channel i-1 performs an add-wrap in wrap mode. It also decrements on the same edge that channel i-1 performs a sub-wrap in wrap mode.
  - The carry/borrow is combinational and ripples through the chain in one cycle, forming one multi-digit counter.
  - The carry is ORed with cnt_add_i[i], and the borrow with cnt_sub_i[i], before the priority logic. A set on channel i still wins.
  - Saturating events do not propagate.
- Without the macro: no inter-channel logic is generated.

Test Plan:
- Reset: assert rst mid-count with no clock edge -> all cnt_o = 0, lim = 39, wrap_o = 0 immediately. After release, 40 adds on ch0 give cnt 39 then 0, and wrap_o[0] is high for exactly one cycle after the wrap edge.
- Saturate: sat_mode_i[1] = 1, lim = 5, cnt = 5, add -> cnt stays 5 and wrap_o[1] pulses. Then sub at 0 -> stays 0 and wrap_o[1] pulses.
- Down-wrap and collisions: ch2 at cnt 0 in wrap mode with lim = 9, sub -> cnt 9 with a pulse. add+sub together -> hold. set 12 with add -> cnt = 9 (clamped), no pulse.
- Limit shrink: ch3 cnt = 30, lim_wr with value 10 plus add on the same edge -> cnt = 10, lim = 10, no wrap. Then add -> cnt 0 with a pulse.
- Limit 0: write lim 0 on ch0, 3 adds -> cnt stays 0, wrap_o[0] high for 3 consecutive cycles.
- Cascade (with COUNTER_BANK_CASCADE_EN): lim = 9 on all channels, ch0 = 9, ch1 = 9, ch2 = 3, add on ch0 -> next edge ch0 = 0, ch1 = 0, ch2 = 4. Without the macro: only ch0 changes.

Source files
------------

// File: rtl/counter_bank.sv
// counter_bank: NUM_CH independent up/down counters with programmable limits,
// wrap/saturate modes and registered wrap pulses. Optional macro COUNTER_BANK_CASCADE_EN
// chains wrap-mode carries/borrows from channel i-1 into channel i.
module counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 6,
  parameter int CNT_MAX   = 39,
  parameter int RST_VAL   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             cnt_add_i,
  input  logic [NUM_CH-1:0]             cnt_sub_i,
  input  logic [NUM_CH-1:0]             cnt_set_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   cnt_set_vector_i,
  input  logic [NUM_CH-1:0]             lim_wr_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   lim_vector_i,
  input  logic [NUM_CH-1:0]             sat_mode_i,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_o,
  output logic [NUM_CH-1:0]             cnt_end_o,
  output logic [NUM_CH-1:0]             cnt_start_o,
  output logic [NUM_CH-1:0]             wrap_o
);

  localparam logic [CNT_WIDTH-1:0] LIM_RST = CNT_WIDTH'(CNT_MAX);
  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(RST_VAL);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] lim_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [CNT_WIDTH-1:0] lim_d [NUM_CH];
  logic [NUM_CH-1:0]    wrap_q;
  logic [NUM_CH-1:0]    wrap_d;

  logic [CNT_WIDTH-1:0] set_val;
  logic [CNT_WIDTH-1:0] new_lim;
  logic                 add_eff;
  logic                 sub_eff;
`ifdef COUNTER_BANK_CASCADE_EN
  logic                 carry;
  logic                 borrow;
`endif

  // Channels are evaluated in index order so a carry/borrow ripples upward
  // through the whole chain within one cycle.
  always_comb begin
    set_val = '0;
    new_lim = '0;
    add_eff = 1'b0;
    sub_eff = 1'b0;
    wrap_d  = '0;
`ifdef COUNTER_BANK_CASCADE_EN
    carry   = 1'b0;
    borrow  = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      set_val  = cnt_set_vector_i[i*CNT_WIDTH +: CNT_WIDTH];
      new_lim  = lim_vector_i[i*CNT_WIDTH +: CNT_WIDTH];
      add_eff  = cnt_add_i[i];
      sub_eff  = cnt_sub_i[i];
`ifdef COUNTER_BANK_CASCADE_EN
      add_eff  = add_eff | carry;
      sub_eff  = sub_eff | borrow;
      carry    = 1'b0;
      borrow   = 1'b0;
`endif
      cnt_d[i] = cnt_q[i];
      lim_d[i] = lim_q[i];
      if (cnt_set_i[i]) begin
        cnt_d[i] = (set_val > lim_q[i]) ? lim_q[i] : set_val;
      end else if (add_eff && sub_eff) begin
        cnt_d[i] = cnt_q[i];
      end else if (add_eff) begin
        // >= also covers an out-of-range count left behind by a limit write
        if (cnt_q[i] >= lim_q[i]) begin
          wrap_d[i] = 1'b1;
          cnt_d[i]  = sat_mode_i[i] ? lim_q[i] : '0;
`ifdef COUNTER_BANK_CASCADE_EN
          carry     = ~sat_mode_i[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end else if (sub_eff) begin
        if (cnt_q[i] == '0) begin
          wrap_d[i] = 1'b1;
          cnt_d[i]  = sat_mode_i[i] ? '0 : lim_q[i];
`ifdef COUNTER_BANK_CASCADE_EN
          borrow    = ~sat_mode_i[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] - ONE;
        end
      end
      // A limit write clamps whatever count was computed; the pulse still stands.
      if (lim_wr_i[i]) begin
        lim_d[i] = new_lim;
        if (cnt_d[i] > new_lim) cnt_d[i] = new_lim;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= CNT_RST;
        lim_q[i] <= LIM_RST;
      end
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        lim_q[i] <= lim_d[i];
      end
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    cnt_o       = '0;
    cnt_end_o   = '0;
    cnt_start_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      cnt_end_o[i]   = (cnt_q[i] == lim_q[i]);
      cnt_start_o[i] = (cnt_q[i] == '0);
    end
  end

  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed scenarios followed by random
// traffic, all compared against an arithmetic reference model of the channel rules.
module tb_counter_bank;

  localparam int N = 4;
  localparam int W = 6;
`ifdef COUNTER_BANK_CASCADE_EN
  localparam bit CASCADE = 1'b1;
`else
  localparam bit CASCADE = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   add, sub, set, lim_wr, sat;
  logic [N*W-1:0] setv, limv;
  logic [N*W-1:0] cnt_o;
  logic [N-1:0]   cnt_end, cnt_start, wrap;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt [N];
  int m_lim [N];
  int m_wrap[N];
  int n_cnt [N];
  int n_lim [N];
  int n_wrap[N];

  counter_bank dut (
    .clk              (clk),
    .rst              (rst),
    .cnt_add_i        (add),
    .cnt_sub_i        (sub),
    .cnt_set_i        (set),
    .cnt_set_vector_i (setv),
    .lim_wr_i         (lim_wr),
    .lim_vector_i     (limv),
    .sat_mode_i       (sat),
    .cnt_o            (cnt_o),
    .cnt_end_o        (cnt_end),
    .cnt_start_o      (cnt_start),
    .wrap_o           (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int ch, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s ch%0d got=%0d exp=%0d", tag, ch, got, exp);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(cnt_o[ch*W +: W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_lim[i] = 39; m_wrap[i] = 0;
    end
  endtask

  // Next state straight from the channel rules, using integer arithmetic.
  task automatic model_next();
    int c, l, n, sv, nl;
    bit a, s, carry, borrow, co, bo;
    carry = 0; borrow = 0;
    for (int i = 0; i < N; i++) begin
      c = m_cnt[i]; l = m_lim[i];
      a = add[i] | (CASCADE & carry);
      s = sub[i] | (CASCADE & borrow);
      co = 0; bo = 0;
      n_wrap[i] = 0;
      if (set[i]) begin
        sv = int'(setv[i*W +: W]);
        n = (sv < l) ? sv : l;
      end else if (a && s) begin
        n = c;
      end else if (a) begin
        if (c >= l) begin
          n_wrap[i] = 1; n = sat[i] ? l : 0; co = !sat[i];
        end else n = c + 1;
      end else if (s) begin
        if (c == 0) begin
          n_wrap[i] = 1; n = sat[i] ? 0 : l; bo = !sat[i];
        end else n = c - 1;
      end else n = c;
      nl = l;
      if (lim_wr[i]) begin
        nl = int'(limv[i*W +: W]);
        if (n > nl) n = nl;
      end
      n_cnt[i] = n; n_lim[i] = nl;
      carry = co; borrow = bo;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check({tag, "_cnt"},   i, cnt_of(i),         m_cnt[i]);
      check({tag, "_wrap"},  i, int'(wrap[i]),     m_wrap[i]);
      check({tag, "_end"},   i, int'(cnt_end[i]),  int'(m_cnt[i] == m_lim[i]));
      check({tag, "_start"}, i, int'(cnt_start[i]), int'(m_cnt[i] == 0));
    end
  endtask

  task automatic tick(input string tag);
    model_next();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = n_cnt[i]; m_lim[i] = n_lim[i]; m_wrap[i] = n_wrap[i];
    end
    check_all(tag);
  endtask

  task automatic idle();
    add = '0; sub = '0; set = '0; lim_wr = '0; setv = '0; limv = '0;
  endtask

  task automatic load(input int ch, input int val);
    set[ch] = 1'b1;
    setv[ch*W +: W] = W'(val);
  endtask

  task automatic wr_lim(input int ch, input int val);
    lim_wr[ch] = 1'b1;
    limv[ch*W +: W] = W'(val);
  endtask

  initial begin
    rst = 1'b0; sat = '0;
    idle();
    model_reset();
    #2 rst = 1'b1;
    #1 check_all("reset_async");
    @(negedge clk) rst = 1'b0;

    // some traffic, then reset asynchronously between edges
    for (int k = 0; k < 12; k++) begin
      add = N'($urandom); sub = N'($urandom);
      tick("pre_reset");
    end
    idle();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("reset_mid");
    @(posedge clk); #1 check_all("reset_held");
    @(negedge clk) rst = 1'b0;

    // 40 adds on ch0: 39 then wrap to 0 with a single pulse
    for (int k = 0; k < 40; k++) begin
      idle(); add[0] = 1'b1;
      tick("add40");
      if (k == 38) check("add40_top", 0, cnt_of(0), 39);
    end
    check("add40_wrapcnt", 0, cnt_of(0), 0);
    check("add40_pulse", 0, int'(wrap[0]), 1);
    idle(); tick("add40_after");
    check("add40_pulse_end", 0, int'(wrap[0]), 0);

    // saturate mode on ch1
    sat = 4'b0010;
    idle(); load(1, 5); wr_lim(1, 5); tick("sat_load");
    idle(); add[1] = 1'b1; tick("sat_add");
    check("sat_add_cnt", 1, cnt_of(1), 5);
    check("sat_add_pulse", 1, int'(wrap[1]), 1);
    idle(); load(1, 0); tick("sat_zero");
    idle(); sub[1] = 1'b1; tick("sat_sub");
    check("sat_sub_cnt", 1, cnt_of(1), 0);
    check("sat_sub_pulse", 1, int'(wrap[1]), 1);
    sat = '0;

    // down-wrap and collisions on ch2
    idle(); load(2, 0); wr_lim(2, 9); tick("dw_load");
    idle(); sub[2] = 1'b1; tick("dw_sub");
    check("dw_sub_cnt", 2, cnt_of(2), 9);
    check("dw_sub_pulse", 2, int'(wrap[2]), 1);
    idle(); add[2] = 1'b1; sub[2] = 1'b1; tick("dw_both");
    check("dw_both_cnt", 2, cnt_of(2), 9);
    idle(); load(2, 12); add[2] = 1'b1; tick("dw_setclamp");
    check("dw_setclamp_cnt", 2, cnt_of(2), 9);
    check("dw_setclamp_pulse", 2, int'(wrap[2]), 0);

    // limit shrink on ch3
    idle(); load(3, 30); tick("shr_load");
    idle(); wr_lim(3, 10); add[3] = 1'b1; tick("shr_wr");
    check("shr_cnt", 3, cnt_of(3), 10);
    check("shr_pulse", 3, int'(wrap[3]), 0);
    check("shr_end", 3, int'(cnt_end[3]), 1);
    idle(); add[3] = 1'b1; tick("shr_add");
    check("shr_add_cnt", 3, cnt_of(3), 0);
    check("shr_add_pulse", 3, int'(wrap[3]), 1);

    // limit 0 on ch0
    idle(); wr_lim(0, 0); tick("lim0_wr");
    for (int k = 0; k < 3; k++) begin
      idle(); add[0] = 1'b1; tick("lim0_add");
      check("lim0_cnt", 0, cnt_of(0), 0);
      check("lim0_pulse", 0, int'(wrap[0]), 1);
    end
    idle(); tick("lim0_idle");

    // cascade arrangement (ripple only when the macro is defined)
    idle(); for (int i = 0; i < N; i++) wr_lim(i, 9); tick("cas_lim");
    idle(); load(0, 9); load(1, 9); load(2, 3); load(3, 0); tick("cas_load");
    idle(); add[0] = 1'b1; tick("cas_add");
    check("cas_ch0", 0, cnt_of(0), 0);
    check("cas_ch1", 1, cnt_of(1), CASCADE ? 0 : 9);
    check("cas_ch2", 2, cnt_of(2), CASCADE ? 4 : 3);
    check("cas_ch3", 3, cnt_of(3), 0);

    // random traffic with small limits so boundaries are hit often
    for (int k = 0; k < 500; k++) begin
      add    = N'($urandom);
      sub    = N'($urandom);
      set    = N'($urandom & $urandom & $urandom);
      lim_wr = N'($urandom & $urandom & $urandom);
      sat    = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        setv[i*W +: W] = W'($urandom_range(0, 20));
        limv[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'(63) : W'($urandom_range(0, 12));
      end
      tick("rand");
    end
    idle(); tick("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
